// File: rtl/key_input_pkg.sv
// rtl/key_input_pkg.sv - shared types, defaults and helpers for the key input scanner
package key_input_pkg;

    // Per-key debounce cell states
    typedef enum logic [1:0] {
        UP       = 2'd0,
        CHK_DOWN = 2'd1,
        DOWN     = 2'd2,
        CHK_UP   = 2'd3
    } cell_state_t;

    localparam int DEF_N_KEYS     = 8;
    localparam int DEF_TICK_DIV   = 50000;
    localparam int DEF_STABLE_CNT = 4;

    // Bits needed to hold values 0..value-1, never less than one bit
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_input_scanner_if.sv
// rtl/key_input_scanner_if.sv - key bank side and debounced result signals of the scanner
interface key_input_scanner_if #(
    parameter int N_KEYS = 8,
    parameter int CODE_W = 3
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_multi;

    // Key bank / consumer side: drives raw keys, observes results
    modport master (
        output key_raw,
        input  key_state, key_press, key_release, key_valid, key_code, key_multi
    );

    // Scanner side
    modport slave (
        input  key_raw,
        output key_state, key_press, key_release, key_valid, key_code, key_multi
    );
endinterface

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - one key: two-flop synchroniser, tick-sampled debounce FSM, edge pulses
module key_debounce_cell
    import key_input_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_key_raw,
    output logic o_state,
    output logic o_press,
    output logic o_release
);
    localparam int CNT_W = clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT);

    logic        r_sync1;
    logic        r_sync2;
    cell_state_t r_state;
    cell_state_t w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic        r_key_state;
    logic        r_press;
    logic        r_release;
    logic        w_enter_down;
    logic        w_enter_up;

    // Two-flop synchroniser for the asynchronous raw key level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State and mismatch counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= UP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: count consecutive ticks that disagree with the accepted level
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        if (i_tick) begin
            case (r_state)
                UP: if (r_sync2) begin
                    if (STABLE_CNT == 1) begin
                        w_next     = DOWN;
                        w_cnt_next = '0;
                    end else begin
                        w_next     = CHK_DOWN;
                        w_cnt_next = CNT_ONE;
                    end
                end
                CHK_DOWN: if (!r_sync2) begin
                    w_next     = UP;
                    w_cnt_next = '0;
                end else if (r_cnt + CNT_ONE == CNT_LAST) begin
                    w_next     = DOWN;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
                DOWN: if (!r_sync2) begin
                    if (STABLE_CNT == 1) begin
                        w_next     = UP;
                        w_cnt_next = '0;
                    end else begin
                        w_next     = CHK_UP;
                        w_cnt_next = CNT_ONE;
                    end
                end
                CHK_UP: if (r_sync2) begin
                    w_next     = DOWN;
                    w_cnt_next = '0;
                end else if (r_cnt + CNT_ONE == CNT_LAST) begin
                    w_next     = UP;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
                default: begin
                    w_next     = UP;
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    assign w_enter_down = (w_next == DOWN) && ((r_state == UP) || (r_state == CHK_DOWN));
    assign w_enter_up   = (w_next == UP)   && ((r_state == DOWN) || (r_state == CHK_UP));

    // Registered level and one-cycle pulses, aligned with the state change
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_state <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_key_state <= (w_next == DOWN) || (w_next == CHK_UP);
            r_press     <= w_enter_down;
            r_release   <= w_enter_up;
        end
    end

    assign o_state   = r_key_state;
    assign o_press   = r_press;
    assign o_release = r_release;
endmodule

// File: rtl/key_input_scanner.sv
// rtl/key_input_scanner.sv - key bank scanner: shared debounce tick, per-key cells, priority encoder
module key_input_scanner
    import key_input_pkg::*;
#(
    parameter int N_KEYS     = DEF_N_KEYS,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int CODE_W     = 3
) (
    input logic clk,
    input logic rst_n,
    key_input_scanner_if.slave key_bus
);
    localparam int TICK_W = clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [N_KEYS-1:0] w_raw;
    logic [N_KEYS-1:0] w_state;
    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_release;
    logic              w_valid;
    logic              w_multi;
    logic [CODE_W-1:0] w_code;

    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign w_raw  = key_bus.key_raw;

    // Free-running sample divider; tick is high on its last count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_cell
        key_debounce_cell #(
            .STABLE_CNT (STABLE_CNT)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (w_tick),
            .i_key_raw (w_raw[g]),
            .o_state   (w_state[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

    // Lowest pressed key wins; multi flags a second pressed key
    always_comb begin
        w_valid = 1'b0;
        w_multi = 1'b0;
        w_code  = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (w_state[i]) w_code = CODE_W'(i);
        end
        for (int i = 0; i < N_KEYS; i++) begin
            if (w_state[i]) begin
                if (w_valid) w_multi = 1'b1;
                w_valid = 1'b1;
            end
        end
    end

    assign key_bus.key_state   = w_state;
    assign key_bus.key_press   = w_press;
    assign key_bus.key_release = w_release;
    assign key_bus.key_valid   = w_valid;
    assign key_bus.key_code    = w_code;
    assign key_bus.key_multi   = w_multi;
endmodule

// File: tb/tb_key_input_scanner.sv
// tb/tb_key_input_scanner.sv - self-checking bench for key_input_scanner with a behavioural reference model
module tb_key_input_scanner;
    localparam int NK = 8;
    localparam int TD = 4;
    localparam int SC = 3;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    key_input_scanner_if #(.N_KEYS(NK), .CODE_W(CW)) kbus ();

    key_input_scanner #(
        .N_KEYS     (NK),
        .TICK_DIV   (TD),
        .STABLE_CNT (SC),
        .CODE_W     (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_bus (kbus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: delayed input, sample phase, accepted level, disagreeing-tick run length
    logic [NK-1:0] m_sync1 = '0;
    logic [NK-1:0] m_sync2 = '0;
    logic [NK-1:0] m_level = '0;
    logic [NK-1:0] m_press = '0;
    logic [NK-1:0] m_release = '0;
    int            m_phase = 0;
    int            m_mism[NK];

    function automatic int lowest_set(input logic [NK-1:0] v);
        for (int i = 0; i < NK; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_edge();
        logic [NK-1:0] prev;
        bit tick;
        if (!rst_n) begin
            m_sync1 = '0; m_sync2 = '0; m_level = '0;
            m_press = '0; m_release = '0; m_phase = 0;
            for (int i = 0; i < NK; i++) m_mism[i] = 0;
        end else begin
            tick    = (m_phase == TD - 1);
            m_phase = (m_phase + 1) % TD;
            prev    = m_level;
            if (tick) begin
                for (int i = 0; i < NK; i++) begin
                    if (m_sync2[i] != m_level[i]) begin
                        m_mism[i]++;
                        if (m_mism[i] == SC) begin
                            m_level[i] = m_sync2[i];
                            m_mism[i]  = 0;
                        end
                    end else begin
                        m_mism[i] = 0;
                    end
                end
            end
            m_press   = m_level & ~prev;
            m_release = ~m_level & prev;
            m_sync2   = m_sync1;
            m_sync1   = kbus.key_raw;
        end
    endtask

    int            cyc = 0;
    int            press_cnt[NK];
    int            rel_cnt[NK];
    int            first_press[NK];
    logic [NK-1:0] seen_state;
    logic          seen_valid;

    task automatic clear_counts();
        for (int i = 0; i < NK; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; first_press[i] = -1;
        end
        seen_state = '0;
        seen_valid = 1'b0;
    endtask

    // One clock: model steps on the edge, DUT compared on the falling edge
    task automatic run1();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("state",   kbus.key_state,   m_level);
        check("press",   kbus.key_press,   m_press);
        check("release", kbus.key_release, m_release);
        check("valid",   kbus.key_valid,   m_level != '0);
        check("code",    kbus.key_code,    lowest_set(m_level));
        check("multi",   kbus.key_multi,   $countones(m_level) >= 2);
        for (int i = 0; i < NK; i++) begin
            press_cnt[i] += kbus.key_press[i];
            rel_cnt[i]   += kbus.key_release[i];
            if (kbus.key_press[i] && first_press[i] < 0) first_press[i] = cyc;
        end
        seen_state |= kbus.key_state;
        seen_valid |= kbus.key_valid;
    endtask

    task automatic wait_state(input logic [NK-1:0] val, input int bound, output int lat);
        lat = 0;
        while (kbus.key_state !== val && lat < bound) begin
            run1();
            lat++;
        end
    endtask

    int lat;
    int steady_cyc;
    int hold;

    initial begin
        for (int i = 0; i < NK; i++) m_mism[i] = 0;
        clear_counts();
        rst_n = 1'b0;
        kbus.key_raw = 8'hFF;
        @(negedge clk);

        // Reset with all keys held
        repeat (5) run1();
        check("rst_state0", kbus.key_state, 0);
        check("rst_press0", kbus.key_press, 0);
        check("rst_valid0", kbus.key_valid, 0);
        check("rst_code0",  kbus.key_code,  0);
        check("rst_multi0", kbus.key_multi, 0);
        rst_n = 1'b1;
        clear_counts();
        wait_state(8'hFF, 40, lat);
        check("rst_acq_state", kbus.key_state, 8'hFF);
        check("rst_acq_lat_ok", (lat >= 11 && lat <= 14), 1);
        repeat (3) run1();
        for (int i = 0; i < NK; i++) begin
            check("rst_press_once", press_cnt[i], 1);
            check("rst_press_same_cycle", first_press[i], first_press[0]);
        end
        kbus.key_raw = 8'h00;
        wait_state(8'h00, 40, lat);
        repeat (3) run1();

        // Clean press and release of key 2
        clear_counts();
        kbus.key_raw = 8'h04;
        wait_state(8'h04, 40, lat);
        check("k2_state", kbus.key_state, 8'h04);
        check("k2_lat_ok", (lat >= 11 && lat <= 14), 1);
        repeat (4) run1();
        check("k2_press_once", press_cnt[2], 1);
        check("k2_code", kbus.key_code, 2);
        check("k2_valid", kbus.key_valid, 1);
        clear_counts();
        kbus.key_raw = 8'h00;
        wait_state(8'h00, 40, lat);
        check("k2_rel_lat_ok", (lat >= 11 && lat <= 14), 1);
        repeat (3) run1();
        check("k2_release_once", rel_cnt[2], 1);
        check("k2_no_press", press_cnt[2], 0);
        check("k2_valid_off", kbus.key_valid, 0);
        check("k2_code_off", kbus.key_code, 0);

        // Short glitch on key 5
        clear_counts();
        kbus.key_raw = 8'h20;
        repeat (5) run1();
        kbus.key_raw = 8'h00;
        repeat (30) run1();
        check("glitch_state", seen_state, 0);
        check("glitch_press", press_cnt[5], 0);
        check("glitch_valid", seen_valid, 0);

        // Bouncing key 1 settling high
        clear_counts();
        for (int c = 0; c < 20; c++) begin
            kbus.key_raw = ((c / 3) % 2 == 0) ? 8'h02 : 8'h00;
            run1();
        end
        steady_cyc = cyc;
        kbus.key_raw = 8'h02;
        repeat (20) run1();
        check("bounce_press_once", press_cnt[1], 1);
        check("bounce_after_steady", first_press[1] > steady_cyc, 1);
        check("bounce_state", kbus.key_state, 8'h02);
        kbus.key_raw = 8'h00;
        wait_state(8'h00, 40, lat);
        repeat (3) run1();

        // Keys 3 and 5 together, then release 3
        clear_counts();
        kbus.key_raw = 8'h28;
        wait_state(8'h28, 40, lat);
        repeat (2) run1();
        check("multi_press3", press_cnt[3], 1);
        check("multi_press5", press_cnt[5], 1);
        check("multi_same_cycle", first_press[3], first_press[5]);
        check("multi_code", kbus.key_code, 3);
        check("multi_flag", kbus.key_multi, 1);
        clear_counts();
        kbus.key_raw = 8'h20;
        wait_state(8'h20, 40, lat);
        repeat (2) run1();
        check("multi_rel_code", kbus.key_code, 5);
        check("multi_rel_flag", kbus.key_multi, 0);
        check("multi_rel3_once", rel_cnt[3], 1);
        check("multi_rel5_none", rel_cnt[5], 0);
        kbus.key_raw = 8'h00;
        wait_state(8'h00, 40, lat);
        repeat (3) run1();

        // Reset while key 6 is held
        kbus.key_raw = 8'h40;
        wait_state(8'h40, 40, lat);
        repeat (2) run1();
        clear_counts();
        rst_n = 1'b0;
        run1();
        check("midrst_state", kbus.key_state, 0);
        check("midrst_release", kbus.key_release, 0);
        rst_n = 1'b1;
        wait_state(8'h40, 40, lat);
        repeat (2) run1();
        check("midrst_reacq_state", kbus.key_state, 8'h40);
        check("midrst_press_once", press_cnt[6], 1);
        check("midrst_no_release", rel_cnt[6], 0);

        // Random hold patterns with occasional single-cycle resets
        for (int s = 0; s < 60; s++) begin
            kbus.key_raw = 8'($urandom);
            hold = $urandom_range(1, 30);
            for (int k = 0; k < hold; k++) begin
                rst_n = ($urandom_range(0, 99) != 0);
                run1();
            end
            rst_n = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
